// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: sequencer state encoding, engine op encoding and default widths.
package jtag_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } seq_state_type;

    localparam logic OP_IR = 1'b0;
    localparam logic OP_DR = 1'b1;

    localparam int DEF_DATA_INSTRUCTION = 10;
    localparam int DEF_DATA_FIFO        = 8;
    localparam int DEF_DR_WORDS         = 4;
    localparam int DEF_TIMEOUT_CYCLES   = 1024;

endpackage

// File: rtl/jtag_seq_watchdog.sv
// Busy watchdog for the scan sequencer: counts cycles while a scan is in flight and
// flags the cycle on which the count would reach TIMEOUT_CYCLES.
module jtag_seq_watchdog
    import jtag_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // Counter sits at zero whenever no scan is in flight, so it is clear on entry to ST_START.
    always_comb begin
        cnt_d  = count_en ? cnt_q + 1'b1 : '0;
        expire = count_en && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/jtag_scan_sequencer.sv
// Command-level JTAG scan sequencer: loads an IR/DR payload into the engine FIFOs, starts
// the engine and reports done. `define JTAG_SEQ_TIMEOUT_EN adds the busy watchdog.
module jtag_scan_sequencer
    import jtag_pkg::*;
#(
    parameter int DATA_INSTRUCTION = DEF_DATA_INSTRUCTION,
    parameter int DATA_FIFO        = DEF_DATA_FIFO,
    parameter int DR_WORDS         = DEF_DR_WORDS,
    parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_op,
    input  logic [DR_WORDS*DATA_FIFO-1:0] cmd_payload,
    output logic                          done,
    output logic [15:0]                   scan_count,
    output logic                          op,
    output logic                          work,
    input  logic                          busy,
    output logic [DATA_INSTRUCTION-1:0]   wdata_instruction,
    output logic                          wr_instruction,
    input  logic                          full_instruction,
    output logic [DATA_FIFO-1:0]          wdata_data,
    output logic                          wr_data,
    input  logic                          full_data
`ifdef JTAG_SEQ_TIMEOUT_EN
   ,output logic                          timeout_err
`endif
);

    localparam int PW    = DR_WORDS * DATA_FIFO;
    localparam int IDX_W = (DR_WORDS > 1) ? $clog2(DR_WORDS) : 1;

    seq_state_type         state_q, state_d;
    logic                  op_q, op_d;
    logic [PW-1:0]         payload_q, payload_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [15:0]           scan_count_q, scan_count_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  done_q, done_d;
    logic                  work_q, work_d;
    logic                  wr_instruction_q, wr_instruction_d;
    logic [DATA_INSTRUCTION-1:0] wdata_instruction_q, wdata_instruction_d;
    logic                  wr_data_q, wr_data_d;
    logic [DATA_FIFO-1:0]  wdata_data_q, wdata_data_d;
    logic                  expire;

`ifdef JTAG_SEQ_TIMEOUT_EN
    logic timeout_err_q, timeout_err_d;

    jtag_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .count_en(state_q == ST_START || state_q == ST_WAIT),
        .expire  (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d             = state_q;
        op_d                = op_q;
        payload_d           = payload_q;
        idx_d               = idx_q;
        scan_count_d        = scan_count_q;
        done_d              = 1'b0;
        wr_instruction_d    = 1'b0;
        wdata_instruction_d = wdata_instruction_q;
        wr_data_d           = 1'b0;
        wdata_data_d        = wdata_data_q;
`ifdef JTAG_SEQ_TIMEOUT_EN
        timeout_err_d       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d      = cmd_op;
                    payload_d = cmd_payload;
                    idx_d     = '0;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (op_q == OP_IR) begin
                    if (!full_instruction) begin
                        wr_instruction_d    = 1'b1;
                        wdata_instruction_d = payload_q[DATA_INSTRUCTION-1:0];
                        state_d             = ST_START;
                    end
                end else if (!full_data) begin
                    // LSB word first: it is the first one the engine shifts out.
                    wr_data_d    = 1'b1;
                    wdata_data_d = payload_q[int'(idx_q)*DATA_FIFO +: DATA_FIFO];
                    idx_d        = idx_q + 1'b1;
                    if (idx_q == IDX_W'(DR_WORDS - 1)) state_d = ST_START;
                end
            end
            ST_START: begin
                if (expire) begin
                    state_d = ST_IDLE;
`ifdef JTAG_SEQ_TIMEOUT_EN
                    timeout_err_d = 1'b1;
`endif
                end else if (busy) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A completion seen on the expiry cycle is still reported as done.
                if (!busy) begin
                    done_d       = 1'b1;
                    scan_count_d = scan_count_q + 16'd1;
                    state_d      = ST_IDLE;
                end else if (expire) begin
                    state_d = ST_IDLE;
`ifdef JTAG_SEQ_TIMEOUT_EN
                    timeout_err_d = 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) op_d = OP_IR;
        work_d      = (state_d == ST_START);
        // Ready only after a full idle cycle, so it never coincides with done.
        cmd_ready_d = (state_q == ST_IDLE) && (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q             <= ST_IDLE;
            op_q                <= OP_IR;
            payload_q           <= '0;
            idx_q               <= '0;
            scan_count_q        <= '0;
            cmd_ready_q         <= 1'b0;
            done_q              <= 1'b0;
            work_q              <= 1'b0;
            wr_instruction_q    <= 1'b0;
            wdata_instruction_q <= '0;
            wr_data_q           <= 1'b0;
            wdata_data_q        <= '0;
        end else begin
            state_q             <= state_d;
            op_q                <= op_d;
            payload_q           <= payload_d;
            idx_q               <= idx_d;
            scan_count_q        <= scan_count_d;
            cmd_ready_q         <= cmd_ready_d;
            done_q              <= done_d;
            work_q              <= work_d;
            wr_instruction_q    <= wr_instruction_d;
            wdata_instruction_q <= wdata_instruction_d;
            wr_data_q           <= wr_data_d;
            wdata_data_q        <= wdata_data_d;
        end
    end

`ifdef JTAG_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) timeout_err_q <= 1'b0;
        else      timeout_err_q <= timeout_err_d;
    end
    assign timeout_err = timeout_err_q;
`endif

    assign cmd_ready         = cmd_ready_q;
    assign done              = done_q;
    assign scan_count        = scan_count_q;
    assign op                = op_q;
    assign work              = work_q;
    assign wr_instruction    = wr_instruction_q;
    assign wdata_instruction = wdata_instruction_q;
    assign wr_data           = wr_data_q;
    assign wdata_data        = wdata_data_q;

endmodule

// File: doc/jtag_scan_sequencer.md
Name: jtag_scan_sequencer

Overview:
Command-level sequencer in front of the jtag engine. It accepts one IR or DR scan command at a time and writes the payload into the engine's instruction or data FIFO. It then starts the engine with a work/op handshake, waits for busy to complete, and reports done. It sits between the host/CSR command source and the jtag engine plus its two FIFOs.

Parameters:
DATA_INSTRUCTION, 10, IR payload width; equals engine instruction FIFO width.
DATA_FIFO, 8, data FIFO word width.
DR_WORDS, 4, data FIFO words consumed per DR scan; engine shifts DATA_FIFO*4 bits.
TIMEOUT_CYCLES, 1024, busy watchdog limit; used only with the optional feature.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer accepts command
cmd_op  in  1  1 = DR scan, 0 = IR scan (same encoding as engine op)
cmd_payload  in  DR_WORDS*DATA_FIFO  DR: full vector; IR: bits [DATA_INSTRUCTION-1:0]
done  out  1  one-cycle pulse, scan finished
scan_count  out  16  completed scans, wraps
op  out  1  to engine
work  out  1  to engine
busy  in  1  from engine
wdata_instruction  out  DATA_INSTRUCTION  instruction FIFO write data
wr_instruction  out  1  instruction FIFO write strobe
full_instruction  in  1  instruction FIFO full
wdata_data  out  DATA_FIFO  data FIFO write data
wr_data  out  1  data FIFO write strobe
full_data  in  1  data FIFO full
timeout_err  out  1  one-cycle pulse; present only with JTAG_SEQ_TIMEOUT_EN

Behaviour:
- Reset (rst=0, async): state ST_IDLE. All of the following are 0: cmd_ready, done, op, work, wr_instruction, wr_data, wdata_*, scan_count, timeout_err. Word index is 0.
- All outputs are registered.
- cmd_ready=1 only in ST_IDLE. Handshake completes on cmd_valid&&cmd_ready.
- On accept: latch cmd_op and cmd_payload, drive op<=cmd_op (held until return to ST_IDLE), word index<=0, go ST_LOAD.
- ST_LOAD, IR (op=0):
  - If !full_instruction: wr_instruction=1 for one cycle with wdata_instruction=payload[DATA_INSTRUCTION-1:0], then go ST_START.
  - If full: wr stays 0 and state holds.
- ST_LOAD, DR (op=1):
  - Each cycle with !full_data: wr_data=1, wdata_data=payload[idx*DATA_FIFO +: DATA_FIFO]. Word 0 is the LSB byte, which is shifted first.
  - Increment idx after each write. After write DR_WORDS-1, go ST_START.
  - full_data stalls: wr_data=0 and idx held.
  - Writes are never issued while full is sampled high.
- ST_START: work=1. Stay until busy=1 is sampled, then work<=0 and go ST_WAIT. Work is therefore low before the engine can return to idle, so no double start is possible.
- ST_WAIT: stay while busy=1. When busy=0 is sampled: done=1 for one cycle, scan_count+=1 (mod 2^16), go ST_IDLE. First cmd_ready is the cycle after done.
- States: ST_IDLE, ST_LOAD, ST_START, ST_WAIT. Any illegal state goes to ST_IDLE.
- Latency, unstalled: IR accept→done = 1 (load) + 1 (start) + engine busy time + 1. DR adds DR_WORDS-1 cycles.
- cmd_valid outside ST_IDLE is ignored; the payload is not re-sampled.
- Reset mid-scan: immediate return to reset values. The FIFO may hold partial words; clearing the FIFOs is the system's job.

Optional Feature:
JTAG_SEQ_TIMEOUT_EN
- Defined:
  - A counter (width $clog2(TIMEOUT_CYCLES)+1) clears on entry to ST_START and counts each cycle in ST_START/ST_WAIT.
  - On reaching TIMEOUT_CYCLES: timeout_err=1 for one cycle, work<=0, go ST_IDLE. No done pulse and no scan_count increment.
  - If busy falls in the same cycle as expiry, completion wins.
- Undefined: no counter, no timeout_err port; the sequencer waits indefinitely.

Decomposition:
- Package jtag_pkg holds:
  - the seq_state_type enum;
  - OP_IR=1'b0 and OP_DR=1'b1;
  - default widths DATA_INSTRUCTION, DATA_FIFO and DR_WORDS, shared with the engine.
- One natural sub-module: jtag_seq_watchdog, the timeout counter, instantiated only under JTAG_SEQ_TIMEOUT_EN.

Test Plan:
- IR command, cmd_op=0, payload=0x2A5 → one wr_instruction with 0x2A5; work high until busy; done one cycle after busy falls; scan_count=1.
- DR command, payload=0xDEADBEEF → wr_data words 0xEF, 0xBE, 0xAD, 0xDE on consecutive cycles; op=1 at work; done after busy falls.
- full_data held high for 5 cycles after word 1 → no writes while full; words 2–3 follow release; order and values are unchanged.
- cmd_valid held high through a scan with changing payload → exactly one accept; next accept the cycle after done; the second scan uses the new payload.
- rst low asserted during ST_WAIT (asynchronously, mid-cycle) → all outputs go to 0 immediately; cmd_ready=1 on the first clk after release.
- With JTAG_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, busy stuck high → timeout_err pulses 16 cycles after entering ST_START; no done; scan_count unchanged; cmd_ready returns.
